gauss_line_ctrl: RTL
====================

GAUSS_LINE_CTRL -- requirements
Module: gauss_line_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter ROW, default 480, input rows per frame.
REQ-003 SHALL have parameter COL, default 752, pixels per row.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-005 SHALL have port en, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, frame start request, sampled in IDLE only.
REQ-007 SHALL have port pix_in, input, WIDTH, incoming raster pixel.
REQ-008 SHALL have port pix_valid, input, 1, pix_in valid.
REQ-009 SHALL have port pix_ready, output, 1, controller accepts pix_in this cycle.
REQ-010 SHALL have ports din_0..din_4, output, WIDTH each, 5-row tap column; din_0 is the current row, din_k is k rows above.
REQ-011 SHALL have ports row_cnt and col_cnt, output, 10 each, coordinates of din_0.
REQ-012 SHALL have port tap_valid, output, 1, taps and coordinates updated this cycle.
REQ-013 SHALL have port kern_en, output, 1, active-low reset/enable for the downstream 5x5 kernel.
REQ-014 SHALL have port busy, output, 1, high outside IDLE.
REQ-015 SHALL have port frame_done, output, 1, single-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-017 IDLE: pix_ready=0, busy=0, kern_en=0; start=1 -> RUN next cycle.
REQ-018 RUN: pix_ready=1; accept = pix_valid & pix_ready; no accept -> taps, counters hold and tap_valid=0.
REQ-019 On accept at internal column c: taps register {pix_in, lb0[c], lb1[c], lb2[c], lb3[c]} onto din_0..din_4, then lb0[c]<=pix_in, lbk[c]<=old lb(k-1)[c]; four COL-deep line buffers.
REQ-020 Tap latency SHALL be 1 cycle: accept in cycle N -> din_*, row_cnt, col_cnt, tap_valid=1 in cycle N+1.
REQ-021 din_k SHALL read 0 while row_cnt < k (rows above frame top); line buffer contents never unmasked before written.
REQ-022 Internal column wraps COL-1 -> 0 with row increment; row_cnt/col_cnt outputs follow internal counters with 1-cycle alignment per REQ-020.
REQ-023 Accept of pixel (row ROW-1, col COL-1) -> FLUSH next cycle.
REQ-024 FLUSH: pix_ready=0; one synthetic column per cycle with pix_in treated as 0 and tap_valid=1, for rows ROW and ROW+1 (row_cnt reaches ROW+1=481 default).
REQ-025 Last flush column (row ROW+1, col COL-1) -> DONE; DONE lasts 1 cycle with frame_done=1, then IDLE.
REQ-026 kern_en SHALL be 1 in RUN, FLUSH, DONE; 0 in IDLE so the kernel is cleared between frames.
REQ-027 start outside IDLE SHALL be ignored; start in the DONE cycle SHALL NOT be captured.
REQ-028 pix_valid while pix_ready=0 SHALL not be consumed nor alter state.
REQ-029 Counters SHALL be 10-bit unsigned, never exceeding ROW+1 / COL-1.

Reset
REQ-030 en=0 SHALL asynchronously force IDLE, row/col counters 0, din_0..din_4=0, tap_valid=0, pix_ready=0, kern_en=0, busy=0, frame_done=0.
REQ-031 Reset mid-RUN/FLUSH SHALL abandon the frame with no frame_done; line buffer contents need no reset (masked by REQ-021).
REQ-032 After en rises, the block SHALL wait in IDLE for start.

Verification (ROW=6, COL=8, WIDTH=8)
REQ-033 Reset, start pulse, continuous pix_valid with pix_in=row*16+col -> at row 4 col 3 taps din_0..din_4 = 0x43,0x33,0x23,0x13,0x03; row_cnt=4, col_cnt=3.
REQ-034 Same stream -> at row 1 col 5: din_0=0x15, din_1=0x05, din_2..din_4=0 (top mask).
REQ-035 Drop pix_valid for 3 cycles mid-row 2 -> tap_valid=0 those cycles, taps/counters frozen, next accept resumes at correct column.
REQ-036 Full frame -> exactly 48 RUN + 16 FLUSH tap_valid cycles, FLUSH din_0=0, final row_cnt=7 col_cnt=7, one frame_done pulse, then IDLE with pix_ready=0.
REQ-037 en=0 at row 3 col 2 -> all outputs 0 immediately; start after release -> new frame begins at row 0 col 0 with din_1..din_4=0.
REQ-038 start asserted during RUN and during DONE -> no state change, no second frame.

Source files
------------

// File: rtl/gauss_line_ctrl_if.sv
// Raster pixel stream into the Gaussian line controller: data, valid, and a ready
// back-pressure signal. The controller takes a pixel only when valid and ready are both high.
interface gauss_line_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;

  modport master (
    output pix_in,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_in,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/gauss_line_ctrl.sv
// Line-buffer controller for a 5x5 Gaussian kernel. It turns a raster stream into a
// 5-row tap column with coordinates, then flushes two blank rows so the kernel can drain.
module gauss_line_ctrl #(
  parameter int WIDTH = 8,
  parameter int ROW   = 480,
  parameter int COL   = 752
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 start,
  gauss_line_ctrl_if.slave     pix,
  output logic [WIDTH-1:0]     din_0,
  output logic [WIDTH-1:0]     din_1,
  output logic [WIDTH-1:0]     din_2,
  output logic [WIDTH-1:0]     din_3,
  output logic [WIDTH-1:0]     din_4,
  output logic [9:0]           row_cnt,
  output logic [9:0]           col_cnt,
  output logic                 tap_valid,
  output logic                 kern_en,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int         CW             = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [9:0] LAST_ROW       = 10'(ROW - 1);
  localparam logic [9:0] LAST_COL       = 10'(COL - 1);
  localparam logic [9:0] LAST_FLUSH_ROW = 10'(ROW + 1);

  logic [1:0]            state_q, state_d;
  logic [9:0]            row_q, row_d;
  logic [9:0]            col_q, col_d;
  logic [4:0][WIDTH-1:0] tap_q, tap_d;
  logic [9:0]            row_cnt_q, row_cnt_d;
  logic [9:0]            col_cnt_q, col_cnt_d;
  logic                  tap_valid_q, tap_valid_d;

  // Four rows of history. lb[0] holds the row just above the current one.
  logic [WIDTH-1:0]      lb [4][COL];

  logic                  in_run;
  logic                  in_flush;
  logic                  step;
  logic                  end_col;
  logic                  last_flush_pos;
  logic [WIDTH-1:0]      pix_eff;
  logic [CW-1:0]         col_idx;

  assign in_run         = (state_q == S_RUN);
  assign in_flush       = (state_q == S_FLUSH);
  assign pix.pix_ready  = in_run;
  // One tap column per accepted pixel in RUN, and one per cycle while flushing.
  assign step           = (in_run & pix.pix_valid) | in_flush;
  assign pix_eff        = in_run ? pix.pix_in : '0;
  assign col_idx        = col_q[CW-1:0];
  assign end_col        = (col_q == LAST_COL);
  assign last_flush_pos = in_flush & (row_q == LAST_FLUSH_ROW) & end_col;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    tap_d       = tap_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    tap_valid_d = step;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_RUN: begin
        if (pix.pix_valid && (row_q == LAST_ROW) && end_col) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (last_flush_pos) begin
          state_d = S_DONE;
        end
      end
      default: begin
        // DONE lasts one cycle, and start is not looked at here.
        state_d = S_IDLE;
      end
    endcase

    if (step) begin
      // Rows above the top of the frame read as zero, so stale line-buffer data never escapes.
      tap_d[0]  = pix_eff;
      tap_d[1]  = (row_q >= 10'd1) ? lb[0][col_idx] : '0;
      tap_d[2]  = (row_q >= 10'd2) ? lb[1][col_idx] : '0;
      tap_d[3]  = (row_q >= 10'd3) ? lb[2][col_idx] : '0;
      tap_d[4]  = (row_q >= 10'd4) ? lb[3][col_idx] : '0;
      row_cnt_d = row_q;
      col_cnt_d = col_q;

      // The position stays on the last flush pixel, so it never exceeds ROW+1 / COL-1.
      if (!last_flush_pos) begin
        if (end_col) begin
          col_d = '0;
          row_d = row_q + 10'd1;
        end else begin
          col_d = col_q + 10'd1;
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      tap_q       <= '0;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      tap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tap_q       <= tap_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      tap_valid_q <= tap_valid_d;
    end
  end

  // NOTE: the line buffers have no reset. This keeps them mappable to RAM, and the row mask above hides anything stale.
  always_ff @(posedge clk) begin
    if (step) begin
      lb[0][col_idx] <= pix_eff;
      lb[1][col_idx] <= lb[0][col_idx];
      lb[2][col_idx] <= lb[1][col_idx];
      lb[3][col_idx] <= lb[2][col_idx];
    end
  end

  assign din_0      = tap_q[0];
  assign din_1      = tap_q[1];
  assign din_2      = tap_q[2];
  assign din_3      = tap_q[3];
  assign din_4      = tap_q[4];
  assign row_cnt    = row_cnt_q;
  assign col_cnt    = col_cnt_q;
  assign tap_valid  = tap_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign kern_en    = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule
